// File: rtl/ternary_weight_packer_pkg.sv
// Shared constants and types for the ternary weight packer and its quantiser.
// Ternary code points, kernel geometry, and the packer's state encoding.
package ternary_weight_packer_pkg;

    localparam int TN              = 4;
    localparam int KERNEL_SIZE     = 5;
    localparam int KERNEL_SIZE_3   = 3;
    localparam int KERNEL_WIDTH    = 2;
    localparam int WEIGHT_IN_WIDTH = 8;

    localparam logic KERNEL_SIZE_5_MODE = 1'b1;
    localparam logic KERNEL_SIZE_3_MODE = ~KERNEL_SIZE_5_MODE;

    localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int KK3    = KERNEL_SIZE_3 * KERNEL_SIZE_3;
    localparam int LANES  = TN * KK;
    localparam int OUT_W  = LANES * KERNEL_WIDTH;
    localparam int KPOS_W = $clog2(KK);
    localparam int TN_W   = (TN > 1) ? $clog2(TN) : 1;
    localparam int LANE_W = $clog2(LANES);

    localparam logic [KERNEL_WIDTH-1:0] TERN_POS  = 2'b01;
    localparam logic [KERNEL_WIDTH-1:0] TERN_NEG  = 2'b11;
    localparam logic [KERNEL_WIDTH-1:0] TERN_ZERO = 2'b00;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } pack_state_e;

    // Last kernel position of a group for the given kernel mode.
    function automatic logic [KPOS_W-1:0] kpos_last(input logic mode);
        if (mode == KERNEL_SIZE_5_MODE) begin
            return KPOS_W'(KK - 1);
        end else begin
            return KPOS_W'(KK3 - 1);
        end
    endfunction

endpackage

// File: rtl/ternary_weight_packer_quantizer.sv
// Combinational ternary quantiser: signed weight against an unsigned magnitude threshold.
// Compared in one extra bit so -128 and a threshold of 255 both behave.
module ternary_quantizer
    import ternary_weight_packer_pkg::*;
(
    input  logic [WEIGHT_IN_WIDTH-1:0] w_data,
    input  logic [WEIGHT_IN_WIDTH-1:0] threshold,
    output logic [KERNEL_WIDTH-1:0]    code
);

    logic signed [WEIGHT_IN_WIDTH:0] w_ext_s;
    logic signed [WEIGHT_IN_WIDTH:0] pos_th_s;
    logic signed [WEIGHT_IN_WIDTH:0] neg_th_s;

    assign w_ext_s  = $signed({w_data[WEIGHT_IN_WIDTH-1], w_data});
    assign pos_th_s = $signed({1'b0, threshold});
    assign neg_th_s = -pos_th_s;

    // Map the weight to +1, -1 or 0; code 10 is unreachable.
    always_comb begin
        code = TERN_ZERO;
        if (w_ext_s > pos_th_s) begin
            code = TERN_POS;
        end else if (w_ext_s < neg_th_s) begin
            code = TERN_NEG;
        end else begin
            code = TERN_ZERO;
        end
    end

endmodule

// File: rtl/ternary_weight_packer.sv
// Packs a stream of quantised weights into one Tn x K x K ternary code vector
// and hands it to the select array over a valid/ready handshake.
module ternary_weight_packer
    import ternary_weight_packer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       kn_size_mode,
    input  logic [WEIGHT_IN_WIDTH-1:0] threshold,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [WEIGHT_IN_WIDTH-1:0] w_data,
    output logic                       pack_valid,
    input  logic                       pack_ready,
    output logic [OUT_W-1:0]           weight_out
);

    pack_state_e             state_r, state_s;
    logic [KPOS_W-1:0]       kpos_r, kpos_s;
    logic [TN_W-1:0]         tn_r, tn_s;
    logic                    mode_r, mode_s;
    logic [OUT_W-1:0]        buf_r, buf_s;
    logic                    w_ready_r;
    logic                    pack_valid_r;

    logic [KERNEL_WIDTH-1:0] code_s;
    logic                    accept_s;
    logic                    first_s;
    logic                    mode_eff_s;
    logic [KPOS_W-1:0]       kpos_last_s;
    logic [LANE_W-1:0]       lane_s;

    ternary_quantizer u_quant (
        .w_data    (w_data),
        .threshold (threshold),
        .code      (code_s)
    );

    assign accept_s    = w_valid && w_ready_r;
    assign first_s     = (kpos_r == {KPOS_W{1'b0}}) && (tn_r == {TN_W{1'b0}});
    // The first weight of a frame sees the live mode; later weights see the latched one.
    assign mode_eff_s  = first_s ? kn_size_mode : mode_r;
    assign kpos_last_s = kpos_last(mode_eff_s);
    assign lane_s      = LANE_W'(tn_r) * LANE_W'(KK) + LANE_W'(kpos_r);

    // Next-state, counter and vector-buffer logic.
    always_comb begin
        state_s = state_r;
        kpos_s  = kpos_r;
        tn_s    = tn_r;
        mode_s  = mode_r;
        buf_s   = buf_r;
        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    if (first_s) begin
                        buf_s  = {OUT_W{1'b0}};
                        mode_s = kn_size_mode;
                    end else begin
                        buf_s  = buf_r;
                        mode_s = mode_r;
                    end
                    buf_s[lane_s*KERNEL_WIDTH +: KERNEL_WIDTH] = code_s;
                    if (kpos_r == kpos_last_s) begin
                        kpos_s = {KPOS_W{1'b0}};
                        if (tn_r == TN_W'(TN - 1)) begin
                            tn_s    = {TN_W{1'b0}};
                            state_s = ST_FULL;
                        end else begin
                            tn_s = tn_r + 1'b1;
                        end
                    end else begin
                        kpos_s = kpos_r + 1'b1;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_FULL: begin
                if (pack_ready) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_FILL;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_FILL;
            kpos_r       <= {KPOS_W{1'b0}};
            tn_r         <= {TN_W{1'b0}};
            mode_r       <= KERNEL_SIZE_5_MODE;
            buf_r        <= {OUT_W{1'b0}};
            w_ready_r    <= 1'b0;
            pack_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            kpos_r       <= kpos_s;
            tn_r         <= tn_s;
            mode_r       <= mode_s;
            buf_r        <= buf_s;
            w_ready_r    <= (state_s == ST_FILL);
            pack_valid_r <= (state_s == ST_FULL);
        end
    end

    assign w_ready    = w_ready_r;
    assign pack_valid = pack_valid_r;
    assign weight_out = buf_r;

endmodule
